// File: rtl/alu_sequencer.sv
// alu_sequencer: pops {op, a, b} entries from an input FIFO, runs them through
// a small ALU (add / subtract, optional 12x12 multiply) and pushes the 25-bit
// result into an output FIFO. Entries carrying an unsupported opcode are
// dropped and counted in a saturating 8-bit error counter.
// Optional feature: define ALU_MUL_EN to enable op=2'b11 (a[11:0]*b[11:0]).
module alu_sequencer #(
    parameter int DATA_SIZE      = 24,
    parameter int OPERATION_SIZE = 2,
    parameter int FIFO_IN_WIDTH  = OPERATION_SIZE + 2 * DATA_SIZE,
    parameter int FIFO_OUT_WIDTH = DATA_SIZE + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [FIFO_IN_WIDTH-1:0]  fifo_in_data,
    input  logic                      empty_in,
    output logic                      r_en_in,
    input  logic                      full_out,
    output logic                      w_en_out,
    output logic [FIFO_OUT_WIDTH-1:0] fifo_out_data,
    output logic                      busy,
    output logic [7:0]                op_err_cnt
);

    localparam logic [OPERATION_SIZE-1:0] OP_ADD = OPERATION_SIZE'(1);
    localparam logic [OPERATION_SIZE-1:0] OP_SUB = OPERATION_SIZE'(2);
`ifdef ALU_MUL_EN
    localparam logic [OPERATION_SIZE-1:0] OP_MUL = OPERATION_SIZE'(3);
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LATCH = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    state_t                      state_reg, state_next;
    logic [OPERATION_SIZE-1:0]   op_reg;
    logic [DATA_SIZE-1:0]        a_reg, b_reg;
    logic [FIFO_OUT_WIDTH-1:0]   result_reg, result_next;
    logic [7:0]                  err_cnt_reg;
    logic                        err_inc;

    logic                        alu_valid;
    logic [FIFO_OUT_WIDTH-1:0]   alu_result;

    // Field split of the input entry: {op, data0, data1}
    logic [OPERATION_SIZE-1:0]   in_op;
    logic [DATA_SIZE-1:0]        in_a, in_b;
    assign in_op = fifo_in_data[FIFO_IN_WIDTH-1 -: OPERATION_SIZE];
    assign in_a  = fifo_in_data[2*DATA_SIZE-1 -: DATA_SIZE];
    assign in_b  = fifo_in_data[DATA_SIZE-1:0];

`ifdef ALU_MUL_EN
    // Only the low 12 bits of each operand feed the multiplier.
    logic [23:0] mul_prod;
    assign mul_prod = a_reg[11:0] * b_reg[11:0];
`endif

    // ALU: decode the latched opcode; zero-extension keeps carry/borrow in the MSB.
    always_comb begin
        alu_valid  = 1'b0;
        alu_result = '0;
        case (op_reg)
            OP_ADD: begin
                alu_valid  = 1'b1;
                alu_result = {1'b0, a_reg} + {1'b0, b_reg};
            end
            OP_SUB: begin
                alu_valid  = 1'b1;
                alu_result = {1'b0, a_reg} - {1'b0, b_reg};
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
                alu_valid  = 1'b1;
                alu_result = FIFO_OUT_WIDTH'(mul_prod);
            end
`endif
            default: ;
        endcase
    end

    // Next-state logic; result and error-count updates only happen in EXEC.
    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        err_inc     = 1'b0;
        case (state_reg)
            ST_IDLE:  if (!empty_in) state_next = ST_READ;
            ST_READ:  state_next = ST_LATCH;
            ST_LATCH: state_next = ST_EXEC;
            ST_EXEC: begin
                if (alu_valid) begin
                    result_next = alu_result;
                    state_next  = ST_WRITE;
                end else begin
                    err_inc    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_WRITE: if (!full_out) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State, operand, result and error-counter registers with async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            op_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            result_reg  <= '0;
            err_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            if (state_reg == ST_LATCH) begin
                op_reg <= in_op;
                a_reg  <= in_a;
                b_reg  <= in_b;
            end
            if (err_inc && (err_cnt_reg != 8'hFF))
                err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    // Strobes are decoded from the state register; the push is held off by
    // the full flag so a stalled WRITE never produces a pulse.
    assign r_en_in       = (state_reg == ST_READ);
    assign w_en_out      = (state_reg == ST_WRITE) && !full_out;
    assign busy          = (state_reg != ST_IDLE);
    assign fifo_out_data = result_reg;
    assign op_err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a queue-based model of the input FIFO
// feeds the DUT, expected results are pushed at stimulus time and a monitor
// pops/compares on every w_en_out pulse. Honours ALU_MUL_EN like the RTL.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [49:0] fifo_in_data = '0;
    logic        empty_in = 1'b1;
    logic        r_en_in;
    logic        full_out = 1'b0;
    logic        w_en_out;
    logic [24:0] fifo_out_data;
    logic        busy;
    logic [7:0]  op_err_cnt;

    int total = 0;
    int bad   = 0;

    logic [49:0] in_q[$];
    logic [24:0] exp_q[$];
    int          err_model = 0;
    int          full_mode = 0;   // 0: never full, 1: always full, 2: random
    bit          lat_check = 1'b0;
    int          cyc = 0;
    int          last_ren = 0;

    alu_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_in_data  (fifo_in_data),
        .empty_in      (empty_in),
        .r_en_in       (r_en_in),
        .full_out      (full_out),
        .w_en_out      (w_en_out),
        .fifo_out_data (fifo_out_data),
        .busy          (busy),
        .op_err_cnt    (op_err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: result of one entry straight from the opcode rules.
    function automatic bit model(input logic [1:0] op, input logic [23:0] a,
                                 input logic [23:0] b, output logic [24:0] r);
        longint la, lb;
        la = longint'(a);
        lb = longint'(b);
        r  = '0;
        if (op == 2'd1) begin
            r = 25'(la + lb);
            return 1'b1;
        end
        if (op == 2'd2) begin
            r = 25'((la + 64'd33554432 - lb) % 64'd33554432);
            return 1'b1;
        end
`ifdef ALU_MUL_EN
        if (op == 2'd3) begin
            r = 25'((la % 4096) * (lb % 4096));
            return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    task automatic send(input logic [1:0] op, input logic [23:0] a, input logic [23:0] b);
        logic [24:0] r;
        if (model(op, a, b, r)) exp_q.push_back(r);
        else if (err_model < 255) err_model++;
        in_q.push_back({op, a, b});
    endtask

    // Input-FIFO model and full flag, driven just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (r_en_in && in_q.size() > 0) fifo_in_data = in_q.pop_front();
            empty_in = (in_q.size() == 0);
            if (full_mode == 2)      full_out = ($urandom_range(0, 3) == 0);
            else                     full_out = (full_mode == 1);
        end
    end

    // Monitor: strobe exclusivity, latency and scoreboard compare on pushes.
    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (r_en_in && w_en_out) begin
                bad++;
                $display("FAIL strobe_overlap: r_en_in=%0b w_en_out=%0b, required not both high", r_en_in, w_en_out);
            end
            if (r_en_in) last_ren = cyc;
            if (w_en_out) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_push: got data=%h, required no push", fifo_out_data);
                end else begin
                    logic [24:0] e;
                    e = exp_q.pop_front();
                    $display("push cyc=%0d data=%h expected=%h", cyc, fifo_out_data, e);
                    if (fifo_out_data !== e) begin
                        bad++;
                        $display("FAIL push_data: got %h, required %h", fifo_out_data, e);
                    end
                end
                if (lat_check) begin
                    total++;
                    if (cyc - last_ren != 3) begin
                        bad++;
                        $display("FAIL latency: read->write %0d cycles, required 3", cyc - last_ren);
                    end
                end
            end
        end
    end

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int idle = 0;
        int n = 0;
        while (idle < 3 && n < 4000) begin
            @(negedge clk);
            n++;
            if (in_q.size() == 0 && !busy && empty_in) idle++;
            else idle = 0;
        end
        total++;
        if (idle < 3) begin
            bad++;
            $display("FAIL drain_%s: timed out with busy=%0b, required idle", tag, busy);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_push_%s: %0d results outstanding, required 0", tag, exp_q.size());
        end
        total++;
        if (op_err_cnt !== 8'(err_model)) begin
            bad++;
            $display("FAIL err_cnt_%s: got %0d, required %0d", tag, op_err_cnt, err_model);
        end
    endtask

    task automatic check1(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    initial begin
        #1;
        check1("reset_r_en", 32'(r_en_in), 0);
        check1("reset_w_en", 32'(w_en_out), 0);
        check1("reset_busy", 32'(busy), 0);
        check1("reset_data", 32'(fifo_out_data), 0);
        check1("reset_err",  32'(op_err_cnt), 0);
        wait_neg(3);
        rst_n = 1'b1;
        wait_neg(2);

        // Directed arithmetic with no back-pressure, latency checked.
        lat_check = 1'b1;
        send(2'b01, 24'hFFFFFF, 24'h000001);
        drain("add");
        check1("add_result", 32'(fifo_out_data), 32'h1000000);
        send(2'b10, 24'h000005, 24'h000007);
        drain("sub");
        check1("sub_result", 32'(fifo_out_data), 32'h1FFFFFE);
        send(2'b00, 24'h123456, 24'h654321);
        drain("inv1");
        check1("inv_first_err", 32'(op_err_cnt), 1);
        check1("inv_holds_data", 32'(fifo_out_data), 32'h1FFFFFE);
        send(2'b11, 24'h000FFF, 24'h000FFF);
        drain("mul");
`ifdef ALU_MUL_EN
        check1("mul_result", 32'(fifo_out_data), 32'h0FFE001);
`else
        check1("mul_dropped_err", 32'(op_err_cnt), 2);
`endif

        // Saturation of the error counter.
        for (int i = 0; i < 299; i++) send(2'b00, 24'($urandom), 24'($urandom));
        drain("sat");
        check1("err_saturated", 32'(op_err_cnt), 32'hFF);

        // Back-pressure: stall in WRITE for 10 cycles, then release.
        lat_check = 1'b0;
        full_mode = 1;
        wait_neg(1);
        send(2'b01, 24'($urandom), 24'($urandom));
        wait_neg(8);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check1("bp_busy", 32'(busy), 1);
            check1("bp_w_en", 32'(w_en_out), 0);
            check1("bp_data", 32'(fifo_out_data), 32'(exp_q[0]));
        end
        full_mode = 0;
        drain("bp");

        // Randomized traffic with random back-pressure.
        full_mode = 2;
        for (int i = 0; i < 80; i++)
            send(2'($urandom_range(0, 3)), 24'($urandom), 24'($urandom));
        drain("rand");
        full_mode = 0;
        wait_neg(2);

        // Reset while stalled in WRITE.
        full_mode = 1;
        wait_neg(1);
        send(2'b10, 24'h00ABCD, 24'h000123);
        wait_neg(8);
        check1("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check1("rst_r_en", 32'(r_en_in), 0);
        check1("rst_w_en", 32'(w_en_out), 0);
        check1("rst_busy", 32'(busy), 0);
        check1("rst_data", 32'(fifo_out_data), 0);
        check1("rst_err",  32'(op_err_cnt), 0);
        exp_q.delete();
        in_q.delete();
        err_model = 0;
        full_mode = 0;
        wait_neg(3);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check1("post_rst_idle", 32'(busy), 0);
            check1("post_rst_r_en", 32'(r_en_in), 0);
        end

        // Resume after reset.
        lat_check = 1'b1;
        send(2'b01, 24'h000010, 24'h000020);
        drain("resume");
        check1("resume_result", 32'(fifo_out_data), 32'h30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
